hazard_lights_n: RTL and testbench

- Parametrised successor to the 3-light hazard FSM: drives N_LIGHTS outputs with selectable animated patterns.
- Adds an internal tick prescaler, an enable, two new modes (bounce, flash) and an error flag for illegal modes.
- Sits between the board top level (switch inputs, LEDR outputs) and runs on a single clock; no divided clock is needed.

---
 rtl/hazard_lights_n.sv | 144 ++++++++++++++
 tb/tb_hazard_lights_n.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_lights_n.sv
// Parametrised hazard-light sequencer: N_LIGHTS outputs animated in calm, sweep,
// bounce or flash patterns, stepped by an enable-gated internal prescaler.
module hazard_lights_n #(
  parameter int N_LIGHTS = 8,
  parameter int TICK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [2:0]          w,
  output logic [N_LIGHTS-1:0] out,
  output logic                step,
  output logic                mode_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALM    = 3'd1,
    S_SWR     = 3'd2,
    S_SWL     = 3'd3,
    S_BOUNCE  = 3'd4,
    S_FLASH   = 3'd5,
    S_ILLEGAL = 3'd6
  } state_t;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [N_LIGHTS-1:0] ONE_L    = {{(N_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [N_LIGHTS-1:0] TOP_L    = ONE_L << (N_LIGHTS - 1);
  localparam logic [N_LIGHTS-1:0] ALL_L    = {N_LIGHTS{1'b1}};
  localparam logic [N_LIGHTS-1:0] ZERO_L   = {N_LIGHTS{1'b0}};
  localparam logic [N_LIGHTS-1:0] CALM_A_L = TOP_L | ONE_L;
  // Odd counts have a single centre light, even counts light the middle pair.
  localparam logic [N_LIGHTS-1:0] CALM_B_L = (N_LIGHTS % 2 == 1) ?
      (ONE_L << ((N_LIGHTS - 1) / 2)) :
      ((ONE_L << (N_LIGHTS / 2)) | (ONE_L << (N_LIGHTS / 2 - 1)));

  function automatic state_t decode_mode(input logic [2:0] sel);
    case (sel)
      3'b000:  return S_CALM;
      3'b001:  return S_SWR;
      3'b010:  return S_SWL;
      3'b011:  return S_BOUNCE;
      3'b100:  return S_FLASH;
      default: return S_ILLEGAL;
    endcase
  endfunction

  logic [CW-1:0]       cnt_r;
  logic                tick_s;
  state_t              state_r, state_nx_s, sel_s;
  logic [N_LIGHTS-1:0] out_r, out_nx_s;
  logic                dir_up_r, dir_up_nx_s;
  logic                step_r, step_nx_s;
  logic                err_r, err_nx_s;

  assign tick_s   = en && (cnt_r == CNT_MAX);
  assign sel_s    = decode_mode(w);
  assign out      = out_r;
  assign step     = step_r;
  assign mode_err = err_r;

  // Prescaler: counts enabled cycles, holds while en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= (cnt_r == CNT_MAX) ? {CW{1'b0}} : cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      out_r    <= ZERO_L;
      dir_up_r <= 1'b1;
      step_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      out_r    <= out_nx_s;
      dir_up_r <= dir_up_nx_s;
      step_r   <= step_nx_s;
      err_r    <= err_nx_s;
    end
  end

  // Next state: load the sampled mode's entry pattern or advance the current one.
  always_comb begin
    state_nx_s  = state_r;
    out_nx_s    = out_r;
    dir_up_nx_s = dir_up_r;
    step_nx_s   = 1'b0;
    err_nx_s    = err_r;
    if (tick_s) begin
      step_nx_s = 1'b1;
      if ((state_r == S_IDLE) || (sel_s != state_r)) begin
        state_nx_s  = sel_s;
        dir_up_nx_s = 1'b1;
        case (sel_s)
          S_CALM:   out_nx_s = CALM_A_L;
          S_SWR:    out_nx_s = ONE_L;
          S_SWL:    out_nx_s = TOP_L;
          S_BOUNCE: out_nx_s = ONE_L;
          S_FLASH:  out_nx_s = ALL_L;
          default:  out_nx_s = ZERO_L;
        endcase
      end else begin
        case (state_r)
          S_CALM:  out_nx_s = (out_r == CALM_A_L) ? CALM_B_L : CALM_A_L;
          S_SWR:   out_nx_s = {out_r[N_LIGHTS-2:0], out_r[N_LIGHTS-1]};
          S_SWL:   out_nx_s = {out_r[0], out_r[N_LIGHTS-1:1]};
          S_FLASH: out_nx_s = (out_r == ALL_L) ? ZERO_L : ALL_L;
          S_BOUNCE: begin
            // Reverse on reaching an end so each endpoint shows for one tick.
            if (dir_up_r) begin
              if (out_r[N_LIGHTS-1]) begin
                out_nx_s    = {1'b0, out_r[N_LIGHTS-1:1]};
                dir_up_nx_s = 1'b0;
              end else begin
                out_nx_s    = {out_r[N_LIGHTS-2:0], 1'b0};
              end
            end else begin
              if (out_r[0]) begin
                out_nx_s    = {out_r[N_LIGHTS-2:0], 1'b0};
                dir_up_nx_s = 1'b1;
              end else begin
                out_nx_s    = {1'b0, out_r[N_LIGHTS-1:1]};
              end
            end
          end
          default: out_nx_s = ZERO_L;
        endcase
      end
      err_nx_s = (state_nx_s == S_ILLEGAL);
    end else begin
      step_nx_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_lights_n.sv
// Directed bench for hazard_lights_n: three instances cover N=5/TICK_DIV=2,
// calm with N=4, and N=3/TICK_DIV=1.
module tb_hazard_lights_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       en5, en4, en3;
  logic [2:0] w5, w4, w3;
  logic [4:0] out5;
  logic [3:0] out4;
  logic [2:0] out3;
  logic       step5, step4, step3;
  logic       err5, err4, err3;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  hazard_lights_n #(.N_LIGHTS(5), .TICK_DIV(2)) dut5 (
    .clk(clk), .reset(reset), .en(en5), .w(w5),
    .out(out5), .step(step5), .mode_err(err5));
  hazard_lights_n #(.N_LIGHTS(4), .TICK_DIV(2)) dut4 (
    .clk(clk), .reset(reset), .en(en4), .w(w4),
    .out(out4), .step(step4), .mode_err(err4));
  hazard_lights_n #(.N_LIGHTS(3), .TICK_DIV(1)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .w(w3),
    .out(out3), .step(step3), .mode_err(err3));

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // dut5 after a tick edge: out and step.
  task automatic chk5(input string tag, input logic [4:0] o, input logic s, input logic e);
    check({tag, "_out"}, 32'(out5), 32'(o));
    check({tag, "_step"}, 32'(step5), 32'(s));
    check({tag, "_err"}, 32'(err5), 32'(e));
  endtask

  logic [4:0] sweep_exp [4] = '{5'b00100, 5'b01000, 5'b10000, 5'b00001};
  logic [4:0] bounce_exp [9] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                                 5'b00100, 5'b00010, 5'b00001, 5'b00010};

  initial begin
    reset = 1'b1;
    en5 = 1'b1; en4 = 1'b1; en3 = 1'b1;
    w5 = 3'b001; w4 = 3'b000; w3 = 3'b001;
    cyc(2);
    chk5("reset5", 5'b00000, 1'b0, 1'b0);
    check("reset4_out", 32'(out4), 32'h0);
    check("reset3_out", 32'(out3), 32'h0);
    check("reset3_step", 32'(step3), 32'h0);
    reset = 1'b0;

    // Edges 1..6 after reset release.
    cyc(1);
    chk5("sw_e1", 5'b00000, 1'b0, 1'b0);
    check("td1_e1_out", 32'(out3), 32'b001);
    check("td1_e1_step", 32'(step3), 32'h1);
    cyc(1);
    chk5("sw_e2", 5'b00001, 1'b1, 1'b0);
    check("calm4_a", 32'(out4), 32'b1001);
    check("td1_e2_out", 32'(out3), 32'b010);
    check("td1_e2_step", 32'(step3), 32'h1);
    cyc(1);
    chk5("sw_e3", 5'b00001, 1'b0, 1'b0);
    check("td1_e3_out", 32'(out3), 32'b100);
    check("td1_e3_step", 32'(step3), 32'h1);
    cyc(1);
    chk5("sw_e4", 5'b00010, 1'b1, 1'b0);
    check("calm4_b", 32'(out4), 32'b0110);
    check("td1_wrap_out", 32'(out3), 32'b001);
    check("td1_wrap_step", 32'(step3), 32'h1);
    cyc(2);
    check("calm4_a2", 32'(out4), 32'b1001);
    chk5("sw_e6", 5'b00100, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      cyc(1);
      check("sw_gap_step", 32'(step5), 32'h0);
      cyc(1);
      chk5("sw_seq", sweep_exp[i], 1'b1, 1'b0);
    end

    // Pause mid-count: one enabled cycle, seven held, then the tick.
    cyc(1);
    en5 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk5("hold", 5'b00001, 1'b0, 1'b0);
    end
    en5 = 1'b1;
    cyc(1);
    chk5("resume", 5'b00010, 1'b1, 1'b0);

    // Sweep left-to-right, then flash with a transient w between ticks.
    w5 = 3'b010;
    cyc(2);
    chk5("swl_entry", 5'b10000, 1'b1, 1'b0);
    cyc(2);
    chk5("swl_adv", 5'b01000, 1'b1, 1'b0);
    w5 = 3'b110;
    cyc(1);
    chk5("between_ticks", 5'b01000, 1'b0, 1'b0);
    w5 = 3'b100;
    cyc(1);
    chk5("flash_entry", 5'b11111, 1'b1, 1'b0);
    cyc(2);
    chk5("flash_off", 5'b00000, 1'b1, 1'b0);
    cyc(2);
    chk5("flash_on", 5'b11111, 1'b1, 1'b0);

    // Illegal mode, repeated, then recovery into calm.
    w5 = 3'b110;
    cyc(2);
    chk5("illegal", 5'b00000, 1'b1, 1'b1);
    cyc(2);
    chk5("illegal_again", 5'b00000, 1'b1, 1'b1);
    w5 = 3'b000;
    cyc(2);
    chk5("calm5_a", 5'b10001, 1'b1, 1'b0);
    cyc(2);
    chk5("calm5_b", 5'b00100, 1'b1, 1'b0);
    cyc(2);
    chk5("calm5_a2", 5'b10001, 1'b1, 1'b0);

    // Bounce across both endpoints.
    w5 = 3'b011;
    cyc(2);
    chk5("bounce_entry", 5'b00001, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc(2);
      chk5("bounce_seq", bounce_exp[i], 1'b1, 1'b0);
    end

    // Reset mid-bounce restarts from the entry pattern.
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk5("bounce_reset", 5'b00000, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1);
    chk5("post_reset_e1", 5'b00000, 1'b0, 1'b0);
    cyc(1);
    chk5("post_reset_entry", 5'b00001, 1'b1, 1'b0);
    cyc(2);
    chk5("post_reset_adv", 5'b00010, 1'b1, 1'b0);

    // Reset also clears a pending mode error.
    w5 = 3'b111;
    cyc(2);
    chk5("illegal2", 5'b00000, 1'b1, 1'b1);
    reset = 1'b1;
    cyc(1);
    chk5("err_reset", 5'b00000, 1'b0, 1'b0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
